// File: rtl/serial_word_transmitter.sv
// Serializes a WIDTH-bit word MSB first under a high serialClock strobe, then enforces a low gap.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the LSB.
module serial_word_transmitter #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] word,
    output logic             busy,
    output logic             done,
    output logic             serialClock,
    output logic             serialData
);

    // state | meaning
    // IDLE  | waiting for start
    // SEND  | shifting frame bits out, serialClock high
    // GAP   | serialClock low until the receiver can re-arm
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BW = (NBITS > 1)      ? $clog2(NBITS)      : 1;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
    localparam logic [CW-1:0] CYC_LOAD = CW'(BIT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [NBITS-1:0] r_shift, w_shift_nxt;
    logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [CW-1:0]    r_cyc_cnt, w_cyc_cnt_nxt;
    logic [GW-1:0]    r_gap_cnt, w_gap_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_sclk, w_sclk_nxt;
    logic             r_sdata, w_sdata_nxt;
    logic [NBITS-1:0] w_load;
    logic [NBITS-1:0] w_shifted;

`ifdef SERIAL_TX_PARITY_EN
    assign w_load = {word, ^word};
`else
    assign w_load = word;
`endif
    assign w_shifted = r_shift << 1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_cyc_cnt <= '0;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_cyc_cnt <= w_cyc_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sdata   <= w_sdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cyc_cnt_nxt = r_cyc_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_sclk_nxt    = r_sclk;
        w_sdata_nxt   = r_sdata;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt   = SEND;
                    w_shift_nxt   = w_load;
                    w_bit_cnt_nxt = '0;
                    w_cyc_cnt_nxt = CYC_LOAD;
                    w_busy_nxt    = 1'b1;
                    w_sclk_nxt    = 1'b1;
                    w_sdata_nxt   = w_load[NBITS-1];
                end
            end
            SEND: begin
                if (r_cyc_cnt != '0) begin
                    w_cyc_cnt_nxt = r_cyc_cnt - 1'b1;
                end else if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt   = GAP;
                    w_gap_cnt_nxt = GAP_LOAD;
                    w_sclk_nxt    = 1'b0;
                    w_sdata_nxt   = 1'b0;
                end else begin
                    // strobe stays high across the bit boundary; only data moves
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_cyc_cnt_nxt = CYC_LOAD;
                    w_shift_nxt   = w_shifted;
                    w_sdata_nxt   = w_shifted[NBITS-1];
                end
            end
            GAP: begin
                if (r_gap_cnt != '0) begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_sclk_nxt  = 1'b0;
                w_sdata_nxt = 1'b0;
            end
        endcase
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign serialClock = r_sclk;
    assign serialData  = r_sdata;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Randomized scoreboard bench for serial_word_transmitter; two lanes run BIT_CYCLES=1 and BIT_CYCLES=3.
module tb_serial_word_transmitter;

    localparam int W   = 8;
    localparam int GAP = 10;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic [W-1:0] w;
        int           e;
    } exp_t;

    task automatic chk(input string nm, input int lane_id, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s lane=%0d edge=%0d got=%0h expected=%0h", nm, lane_id, edge_n, act, expv);
        end
    endtask

    // Frame bit idx: data MSB first, then (if enabled) the even-parity bit.
    function automatic logic exp_bit(input logic [W-1:0] w, input int idx);
        if (idx < W) return w[W-1-idx];
        return logic'($countones(w) % 2);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int BC = (g == 0) ? 1 : 3;
        localparam int L  = NB * BC;

        logic         rst_n = 1'b0;
        logic         start = 1'b0;
        logic [W-1:0] word  = '0;
        logic         busy, done, sclk, sdata;
        exp_t         q[$];
        int           next_ok = 0;
        bit           fin = 1'b0;

        serial_word_transmitter #(
            .WIDTH(W), .BIT_CYCLES(BC), .GAP_CYCLES(GAP)
        ) dut (
            .clock(clk), .reset_n(rst_n), .start(start), .word(word),
            .busy(busy), .done(done), .serialClock(sclk), .serialData(sdata)
        );

        task automatic step(input logic st, input logic [W-1:0] w);
            int s;
            start = st;
            word  = w;
            s = edge_n + 1;
            if (st && rst_n && s >= next_ok) begin
                q.push_back('{w: w, e: s});
                next_ok = s + L + GAP + 1;
            end
            @(posedge clk);
            #1;
        endtask

        task automatic idle_until_free();
            while (edge_n + 1 < next_ok) step(1'b0, 8'($urandom));
        endtask

        initial begin
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (20) step(1'b0, 8'h00);
            step(1'b1, (g == 0) ? 8'hA5 : 8'h81);
            idle_until_free();
            for (int i = 0; i < 150; i++) step($urandom_range(0, 3) == 0, 8'($urandom));
            idle_until_free();
            step(1'b1, 8'h5A);
            repeat (3) step(1'b0, 8'($urandom));
            step(1'b1, 8'hFF);
            idle_until_free();
            repeat (3 * (L + GAP + 1)) step(1'b1, 8'h3C);
            idle_until_free();
            step(1'b1, 8'hA5);
            repeat (4) step(1'b0, 8'h00);
            #2 rst_n = 1'b0;
            #1;
            chk("async_reset_busy", g, 32'(busy), 32'd0);
            chk("async_reset_done", g, 32'(done), 32'd0);
            chk("async_reset_sclk", g, 32'(sclk), 32'd0);
            chk("async_reset_sdata", g, 32'(sdata), 32'd0);
            q.delete();
            next_ok = 0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (5) step(1'b0, 8'h00);
            step(1'b1, 8'h07);
            idle_until_free();
            repeat (5) step(1'b0, 8'h00);
            fin = 1'b1;
        end

        // Output nibble is {busy, done, serialClock, serialData}.
        initial begin
            bit           act = 1'b0;
            exp_t         cur;
            int           off;
            logic [3:0]   expv;
            cur = '{w: '0, e: 0};
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    act = 1'b0;
                    chk("reset_outputs", g, 32'({busy, done, sclk, sdata}), 32'd0);
                end else begin
                    if (q.size() != 0 && q[0].e == edge_n) begin
                        cur = q.pop_front();
                        act = 1'b1;
                    end
                    expv = 4'b0000;
                    if (act) begin
                        off = edge_n - cur.e;
                        if (off < L) expv = {1'b1, 1'b0, 1'b1, exp_bit(cur.w, off / BC)};
                        else if (off < L + GAP) expv = 4'b1000;
                        else begin
                            expv = 4'b0100;
                            act  = 1'b0;
                        end
                    end
                    chk(act || expv != 4'b0000 ? "frame_outputs" : "idle_outputs", g,
                        32'({busy, done, sclk, sdata}), 32'(expv));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(lane[0].fin && lane[1].fin); i++) @(posedge clk);
        chk("lanes_finished", 0, 32'({lane[0].fin, lane[1].fin}), 32'd3);
        chk("queue_drained", 0, 32'(lane[0].q.size() + lane[1].q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
